plic_port_arbiter: RTL
======================

# plic_port_arbiter

Round-robin arbiter that shares the single PLIC MMIO register port (offset/we/wdata/re in, rdata out) between N_REQ requesters, e.g. the CPU load/store path and the debug/boot loader. It serializes accesses into the PLIC's fixed timing: one issue cycle, then registered read data one cycle later. It guarantees that each read strobe, and therefore each claim side effect, is issued exactly once per granted read. It sits between the bus decoder for base 0x50000000 and the plic instance.

## Interface
- N_REQ, 2, number of requesters (≥2)
- W_OFFSET, 30, PLIC offset width
- CLK  in  1  clock
- RST  in  1  synchronous, active-high reset
- i_req  in  N_REQ  per-requester request, held until its ack
- i_we  in  N_REQ  1 = write, 0 = read; valid while i_req
- i_offset  in  N_REQ*W_OFFSET  byte offset; requester k at bits [k*W_OFFSET +: W_OFFSET]
- i_wdata  in  N_REQ*32  write data; requester k at [k*32 +: 32]
- o_ack  out  N_REQ  one-cycle completion pulse; at most one bit set
- o_rdata  out  32  read data, valid only in the o_ack cycle of a read
- o_busy  out  1  transaction in flight (state ≠ IDLE)
- w_offset  out  W_OFFSET  to PLIC
- w_we  out  1  to PLIC write enable
- w_wdata  out  32  to PLIC
- w_re  out  1  to PLIC read enable (claim strobe)
- w_rdata  in  32  from PLIC; registered inside PLIC, reflects the offset of the previous cycle

## Operation
- FSM states: IDLE, ISSUE, RESP.
- IDLE:
  - If any i_req is set, select the winner by round-robin. Search starts at r_last+1 and wraps modulo N_REQ.
  - Latch winner index, we, offset, wdata into r_idx, r_we, r_off, r_wd.
  - Set r_last ← winner. Go to ISSUE.
  - If no request, stay in IDLE.
- ISSUE, exactly one cycle:
  - w_offset = r_off, w_wdata = r_wd.
  - w_we = r_we, w_re = !r_we.
  - Go to RESP.
- RESP, exactly one cycle:
  - o_ack[r_idx] = 1.
  - o_rdata = r_we ? 0 : w_rdata.
  - Go to IDLE.
- Outside ISSUE: w_offset = 0, w_wdata = 0, w_we = 0, w_re = 0. Offset 0 is reserved, so PLIC reads it as 0 with no side effects.
- A requester that keeps i_req high in the IDLE cycle after its ack is treated as issuing a new transaction. Requesters drop i_req on the edge that samples o_ack if they have nothing further.
- Changes on a requester's inputs while it is waiting are ignored once latched. Non-granted requesters keep waiting with no timeout.
- The arbiter does not decode offsets. Any offset is forwarded unchanged, including reserved ones.
- Fairness: with all N_REQ requesting continuously, each is granted once per N_REQ transactions.

## Timing
- Reset values: state = IDLE, r_last = N_REQ-1 (requester 0 wins first), r_idx/r_we/r_off/r_wd = 0, o_ack = 0, o_rdata = 0, o_busy = 0, all w_* = 0.
- While RST is high, the w_* outputs are forced to 0 in the same cycle. A reset during ISSUE therefore issues no PLIC access, and a reset during RESP produces no ack.
- Latency: i_req sampled in IDLE at cycle t → ISSUE at t+1 → o_ack at t+2. A new transaction can start at t+3.
- Peak throughput is 1 transaction per 3 cycles.
- w_re is high for exactly one cycle per granted read. No PLIC strobe is ever repeated, so one claim is made per read.
- Back-to-back claim reads: the second read's ISSUE occurs ≥2 cycles after the first, so r_claim in the PLIC has recomputed by then.
- Outputs are a registered state plus combinational muxing of registers. Only o_rdata passes w_rdata through combinationally.

## Structure
- Shared package (plic_pkg): state encodings S_IDLE/S_ISSUE/S_RESP, PLIC offset constants (PLIC_CLAIM_BASE 0x200004, PLIC_CTX_STRIDE 0x1000) for the bench.
- The index width is max(1,$clog2(N_REQ)).
- One sub-module: rr_pick, a combinational round-robin priority encoder with inputs req vector and last index, and outputs a valid flag and the winner index. It is reusable by other bus arbiters.

## Test plan
- Single read: after reset, req0 reads 0x200004 with PLIC claim = 5 → w_re is high for one cycle with w_offset 0x200004; o_ack[0] two cycles after the request with o_rdata = 5; the source-5 pending bit clears.
- Single write: req1 writes 0x000008 with 0x3 → w_we is high for one cycle with w_wdata = 3; o_ack[1] at t+2; a subsequent read of 0x8 returns 3.
- Contention: req0 and req1 both held high for 6 transactions → grant order 0,1,0,1,0,1; o_ack spaced 3 cycles apart; never two ack bits at once.
- Claim uniqueness: two sources with equal priority pending, both requesters read claim back-to-back → returned IDs 1 then 2; exactly two w_re pulses.
- Reset mid-transaction: RST asserted in the ISSUE cycle of a write to 0x200000 → w_we stays 0, no o_ack, threshold unchanged; after release, requester 0 wins first.
- Idle bus: no requests for 20 cycles → w_we = w_re = 0, w_offset = 0, o_busy = 0 throughout.

Source files
------------

// File: rtl/plic_pkg.sv
// Shared definitions for the PLIC register-port arbiter and its bench.
// FSM encodings plus the PLIC context-0 offsets used to exercise claims.
package plic_pkg;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_RESP  = 2'd2
  } arb_state_t;

  localparam logic [31:0] PLIC_CLAIM_BASE = 32'h0020_0004;
  localparam logic [31:0] PLIC_CTX_STRIDE = 32'h0000_1000;

endpackage

// File: rtl/plic_port_arbiter_rr_pick.sv
// Combinational round-robin priority encoder: search starts at last+1 and wraps.
// Zero latency; no backpressure, vld simply drops when no request is present.
module rr_pick #(
  parameter int N  = 2,
  parameter int IW = 1
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] last,
  output logic          vld,
  output logic [IW-1:0] idx
);

  logic [IW-1:0] k;

  always_comb begin
    vld = 1'b0;
    idx = '0;
    k   = '0;
    for (int i = 1; i <= N; i++) begin
      k = IW'((int'(last) + i) % N);
      if (!vld && req[k]) begin
        vld = 1'b1;
        idx = k;
      end
    end
  end

endmodule

// File: rtl/plic_port_arbiter.sv
// Round-robin sharing of the single PLIC MMIO port between N_REQ requesters.
// Request sampled in IDLE -> ISSUE next cycle -> o_ack after; losers wait with i_req held.
module plic_port_arbiter
  import plic_pkg::*;
#(
  parameter int N_REQ    = 2,
  parameter int W_OFFSET = 30
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic [N_REQ-1:0]      i_req,
  input  logic [N_REQ-1:0]      i_we,
  input  logic [N_REQ*W_OFFSET-1:0] i_offset,
  input  logic [N_REQ*32-1:0]   i_wdata,
  output logic [N_REQ-1:0]      o_ack,
  output logic [31:0]           o_rdata,
  output logic                  o_busy,
  output logic [W_OFFSET-1:0]   w_offset,
  output logic                  w_we,
  output logic [31:0]           w_wdata,
  output logic                  w_re,
  input  logic [31:0]           w_rdata
);

  localparam int IW = (N_REQ > 1) ? $clog2(N_REQ) : 1;

  arb_state_t          state, state_nxt;
  logic [IW-1:0]       r_last, r_idx;
  logic                r_we;
  logic [W_OFFSET-1:0] r_off;
  logic [31:0]         r_wd;
  logic                pick_vld;
  logic [IW-1:0]       pick_idx;

  rr_pick #(
    .N  (N_REQ),
    .IW (IW)
  ) u_rr_pick (
    .req  (i_req),
    .last (r_last),
    .vld  (pick_vld),
    .idx  (pick_idx)
  );

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (pick_vld) state_nxt = S_ISSUE;
      S_ISSUE: state_nxt = S_RESP;
      S_RESP:  state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state  <= S_IDLE;
      r_last <= IW'(N_REQ - 1);
      r_idx  <= '0;
      r_we   <= 1'b0;
      r_off  <= '0;
      r_wd   <= '0;
    end else begin
      state <= state_nxt;
      // The whole request is captured once; later changes on the inputs are ignored.
      if (state == S_IDLE && pick_vld) begin
        r_last <= pick_idx;
        r_idx  <= pick_idx;
        r_we   <= i_we[pick_idx];
        r_off  <= i_offset[int'(pick_idx)*W_OFFSET +: W_OFFSET];
        r_wd   <= i_wdata[int'(pick_idx)*32 +: 32];
      end
    end
  end

  // RST gates the strobes immediately so a reset in ISSUE never reaches the PLIC.
  always_comb begin
    w_offset = '0;
    w_wdata  = '0;
    w_we     = 1'b0;
    w_re     = 1'b0;
    o_ack    = '0;
    o_rdata  = '0;
    if (!RST) begin
      case (state)
        S_ISSUE: begin
          w_offset = r_off;
          w_wdata  = r_wd;
          w_we     = r_we;
          w_re     = !r_we;
        end
        S_RESP: begin
          o_ack[r_idx] = 1'b1;
          o_rdata      = r_we ? 32'h0 : w_rdata;
        end
        default: ;
      endcase
    end
  end

  assign o_busy = (state != S_IDLE);

endmodule
